// File: rtl/diag_loop_chain_array.sv
// diag_loop_chain_array
// Diagnostic loop-chain block for the systolic-array self-test path.
// Per-column mismatch flags arrive one row per accepted beat and are folded
// into per-column recirculating sticky (OR-loop) chains over one or more
// passes. At the end of the run the accumulated PE map is classified into
// faulty rows / faulty columns against fixed thresholds.
//
// Optional build macro DIAG_FAULT_CNT_EN adds output fault_cnt, the total
// number of set bits in fault_map, registered together with the results.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; previous results held
// S_RUN  | accepting beats (fault_vld=1), stalled when fault_vld=0
// S_EVAL | one cycle: chains -> fault_map, row/col classification
// S_DONE | one cycle: done pulse, results valid; start accepted here too

module diag_loop_chain_array #(
  parameter int COLS    = 8,
  parameter int DEPTH   = 8,
  parameter int ROW_THR = 3,
  parameter int COL_THR = 3,
  parameter int PASS_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [PASS_W-1:0]        passes,
  input  logic                     fault_vld,
  input  logic [COLS-1:0]          fault_in,
  output logic                     busy,
  output logic                     done,
  output logic [DEPTH-1:0]         row_fault,
  output logic [COLS-1:0]          col_fault,
  output logic [COLS*DEPTH-1:0]    fault_map
`ifdef DIAG_FAULT_CNT_EN
  ,
  output logic [$clog2(COLS*DEPTH+1)-1:0] fault_cnt
`endif
);

  localparam int PH_W = $clog2(DEPTH);
  localparam int RW   = $clog2(COLS + 1);
  localparam int CW   = $clog2(DEPTH + 1);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DEPTH - 1);
  localparam logic [RW-1:0]     ROW_THR_V = RW'(ROW_THR);
  localparam logic [CW-1:0]     COL_THR_V = CW'(COL_THR);
  localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_EVAL,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // chain[c][i] is slot i of column c's loop; slot 0 receives the new beat
  logic [COLS-1:0][DEPTH-1:0] chain;
  logic [COLS-1:0][DEPTH-1:0] chain_rot;
  logic [PH_W-1:0]            phase;
  logic [PASS_W-1:0]          pass_cnt;

  logic start_acc;
  logic beat;
  logic last_beat;

  logic [COLS*DEPTH-1:0] map_nxt;
  logic [DEPTH-1:0]      row_nxt;
  logic [COLS-1:0]       col_nxt;
  logic [RW-1:0]         rcnt;
  logic [CW-1:0]         ccnt;

  assign last_beat = (phase == PH_LAST) && (pass_cnt == PASS_ONE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, handshake outputs and beat/start qualification
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    beat      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (fault_vld) begin
          beat = 1'b1;
          if (last_beat) state_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Rotate every chain by one slot, OR-ing the recirculated tail into slot 0
  always_comb begin
    chain_rot = '0;
    for (int c = 0; c < COLS; c++) begin
      chain_rot[c] = {chain[c][DEPTH-2:0], fault_in[c] | chain[c][DEPTH-1]};
    end
  end

  // Unfold chains into the PE map and classify rows / columns
  always_comb begin
    map_nxt = '0;
    row_nxt = '0;
    col_nxt = '0;
    rcnt    = '0;
    ccnt    = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < COLS; c++) begin
        map_nxt[r*COLS+c] = chain[c][DEPTH-1-r];
      end
    end
    for (int r = 0; r < DEPTH; r++) begin
      rcnt = '0;
      for (int c = 0; c < COLS; c++) begin
        rcnt = rcnt + RW'(map_nxt[r*COLS+c]);
      end
      row_nxt[r] = (rcnt >= ROW_THR_V);
    end
    for (int c = 0; c < COLS; c++) begin
      ccnt = '0;
      for (int r = 0; r < DEPTH; r++) begin
        ccnt = ccnt + CW'(map_nxt[r*COLS+c]);
      end
      col_nxt[c] = (ccnt >= COL_THR_V);
    end
  end

  // Chains, phase and pass counters; clear on accepted start, advance on beats
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain    <= '0;
      phase    <= '0;
      pass_cnt <= '0;
    end else if (start_acc) begin
      chain    <= '0;
      phase    <= '0;
      pass_cnt <= (passes == '0) ? PASS_ONE : passes;
    end else if (beat) begin
      chain <= chain_rot;
      if (phase == PH_LAST) begin
        phase    <= '0;
        pass_cnt <= pass_cnt - PASS_ONE;
      end else begin
        phase <= phase + PH_W'(1);
      end
    end
  end

  // Result registers: cleared on accepted start, loaded in EVAL, held otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_map <= '0;
      row_fault <= '0;
      col_fault <= '0;
    end else if (start_acc) begin
      fault_map <= '0;
      row_fault <= '0;
      col_fault <= '0;
    end else if (state == S_EVAL) begin
      fault_map <= map_nxt;
      row_fault <= row_nxt;
      col_fault <= col_nxt;
    end
  end

`ifdef DIAG_FAULT_CNT_EN
  localparam int TW = $clog2(COLS*DEPTH + 1);
  logic [TW-1:0] tcnt;

  // Total set bits of the map about to be registered
  always_comb begin
    tcnt = '0;
    for (int i = 0; i < COLS*DEPTH; i++) begin
      tcnt = tcnt + TW'(map_nxt[i]);
    end
  end

  // Total fault count register, same lifetime as the other results
  always_ff @(posedge clk) begin
    if (!rst_n)               fault_cnt <= '0;
    else if (start_acc)       fault_cnt <= '0;
    else if (state == S_EVAL) fault_cnt <= tcnt;
  end
`endif

endmodule

// File: tb/tb_diag_loop_chain_array.sv
// Bench for diag_loop_chain_array (default parameters). Expected results come
// from a PE-grid model: every accepted beat b ORs its flags into row b%DEPTH.
module tb_diag_loop_chain_array;

  localparam int COLS  = 8;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  passes = '0;
  logic        fault_vld = 1'b0;
  logic [7:0]  fault_in = '0;
  logic        busy, done;
  logic [7:0]  row_fault, col_fault;
  logic [63:0] fault_map;
`ifdef DIAG_FAULT_CNT_EN
  logic [6:0]  fault_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0]  pat [0:127];
  logic [63:0] exp_map;
  logic [7:0]  exp_row, exp_col;
  int          exp_cnt;

  diag_loop_chain_array dut (
    .clk(clk), .rst_n(rst_n), .start(start), .passes(passes),
    .fault_vld(fault_vld), .fault_in(fault_in), .busy(busy), .done(done),
    .row_fault(row_fault), .col_fault(col_fault), .fault_map(fault_map)
`ifdef DIAG_FAULT_CNT_EN
    , .fault_cnt(fault_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: fold beats into the PE grid, then count rows / columns
  task automatic model(input int nbeats);
    int rc, cc;
    exp_map = '0; exp_row = '0; exp_col = '0; exp_cnt = 0;
    for (int b = 0; b < nbeats; b++)
      for (int c = 0; c < COLS; c++)
        if (pat[b][c]) exp_map[(b % DEPTH)*COLS + c] = 1'b1;
    for (int r = 0; r < DEPTH; r++) begin
      rc = 0;
      for (int c = 0; c < COLS; c++) rc += exp_map[r*COLS+c];
      if (rc >= 3) exp_row[r] = 1'b1;
      exp_cnt += rc;
    end
    for (int c = 0; c < COLS; c++) begin
      cc = 0;
      for (int r = 0; r < DEPTH; r++) cc += exp_map[r*COLS+c];
      if (cc >= 3) exp_col[c] = 1'b1;
    end
  endtask

  // Drives one run from the current cycle (called #1 after a posedge).
  // Returns start-to-done latency (-1 on timeout) and the stall count.
  task automatic drive_run(input int np, input bit stall, input bit mid_start,
                           output int lat, output int nstall);
    int nb, b, i, s0;
    nb = ((np == 0) ? 1 : np) * DEPTH;
    b = 0; i = 0; nstall = 0;
    start = 1'b1; passes = 4'(np); fault_vld = 1'b0; fault_in = 8'($urandom);
    s0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (b < nb) begin
      fault_vld = stall ? (i % 2 == 0) : 1'b1;
      fault_in  = fault_vld ? pat[b] : 8'($urandom);
      start     = mid_start && (i == 5);
      if (mid_start) passes = 4'($urandom);
      @(posedge clk); #1;
      if (fault_vld) b++; else nstall++;
      i++;
    end
    start = 1'b0; fault_vld = 1'b1; fault_in = 8'hFF;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = cyc - s0;
        break;
      end
      @(posedge clk); #1;
    end
    fault_vld = 1'b0; fault_in = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; fault_vld = 1'b1; fault_in = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
        n_err++; $display("FAIL reset_idle_hs cyc%0d busy/done=%b expected 00", k, {busy, done});
      end
      n_cmp++;
      if ({fault_map, row_fault, col_fault} !== '0) begin
        n_err++; $display("FAIL reset_idle_res cyc%0d map=%h row=%h col=%h expected 0", k, fault_map, row_fault, col_fault);
      end
    end
    fault_vld = 1'b0; fault_in = '0;
  endtask

  task automatic test_single_pe();
    int lat, ns;
    for (int b = 0; b < 128; b++) pat[b] = '0;
    pat[5] = 8'h04;
    model(8);
    drive_run(1, 1'b0, 1'b0, lat, ns);
    n_cmp++;
    if (lat !== 10) begin n_err++; $display("FAIL single_lat got %0d expected 10", lat); end
    n_cmp++;
    if (fault_map !== exp_map) begin n_err++; $display("FAIL single_map got %h expected %h", fault_map, exp_map); end
    n_cmp++;
    if ({row_fault, col_fault} !== {exp_row, exp_col}) begin
      n_err++; $display("FAIL single_rc got %h/%h expected %h/%h", row_fault, col_fault, exp_row, exp_col);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_at_done got %b expected 0", busy); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({done, fault_map} !== {1'b0, exp_map}) begin
      n_err++; $display("FAIL single_hold done=%b map=%h expected 0/%h", done, fault_map, exp_map);
    end
  endtask

  task automatic test_row_fault();
    int lat, ns;
    for (int b = 0; b < 128; b++) pat[b] = '0;
    pat[3] = 8'hE0;
    model(8);
    drive_run(1, 1'b0, 1'b0, lat, ns);
    n_cmp++;
    if (lat !== 10) begin n_err++; $display("FAIL row_lat got %0d expected 10", lat); end
    n_cmp++;
    if (fault_map !== exp_map) begin n_err++; $display("FAIL row_map got %h expected %h", fault_map, exp_map); end
    n_cmp++;
    if ({row_fault, col_fault} !== {exp_row, exp_col}) begin
      n_err++; $display("FAIL row_rc got %h/%h expected %h/%h", row_fault, col_fault, exp_row, exp_col);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_col_multipass();
    int lat, ns;
    for (int b = 0; b < 128; b++) pat[b] = '0;
    pat[0] = 8'h02; pat[7] = 8'h02; pat[12] = 8'h02; pat[8] = 8'h02;
    model(16);
    drive_run(2, 1'b0, 1'b0, lat, ns);
    n_cmp++;
    if (lat !== 18) begin n_err++; $display("FAIL col_lat got %0d expected 18", lat); end
    n_cmp++;
    if (fault_map !== exp_map) begin n_err++; $display("FAIL col_map got %h expected %h", fault_map, exp_map); end
    n_cmp++;
    if ({row_fault, col_fault} !== {exp_row, exp_col}) begin
      n_err++; $display("FAIL col_rc got %h/%h expected %h/%h", row_fault, col_fault, exp_row, exp_col);
    end
`ifdef DIAG_FAULT_CNT_EN
    n_cmp++;
    if (fault_cnt !== 7'(exp_cnt)) begin n_err++; $display("FAIL col_cnt got %0d expected %0d", fault_cnt, exp_cnt); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_stall_busy_start();
    int lat, ns;
    for (int b = 0; b < 128; b++) pat[b] = '0;
    pat[3] = 8'hE0;
    model(8);
    drive_run(1, 1'b1, 1'b1, lat, ns);
    n_cmp++;
    if (lat !== 10 + ns) begin n_err++; $display("FAIL stall_lat got %0d expected %0d", lat, 10 + ns); end
    n_cmp++;
    if (fault_map !== exp_map) begin n_err++; $display("FAIL stall_map got %h expected %h", fault_map, exp_map); end
    n_cmp++;
    if ({row_fault, col_fault} !== {exp_row, exp_col}) begin
      n_err++; $display("FAIL stall_rc got %h/%h expected %h/%h", row_fault, col_fault, exp_row, exp_col);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL stall_after_done busy/done=%b expected 00", {busy, done}); end
  endtask

  task automatic test_reset_mid_run();
    int lat, ns;
    start = 1'b1; passes = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_run got %b expected 1", busy); end
    for (int k = 0; k < 4; k++) begin
      fault_vld = 1'b1; fault_in = 8'($urandom);
      @(posedge clk); #1;
    end
    rst_n = 1'b0; fault_vld = 1'b1; fault_in = 8'hFF;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, fault_map, row_fault, col_fault} !== '0) begin
      n_err++; $display("FAIL midrst_clear busy=%b done=%b map=%h row=%h col=%h expected 0", busy, done, fault_map, row_fault, col_fault);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL midrst_idle cyc%0d busy/done=%b expected 00", k, {busy, done}); end
    end
    fault_vld = 1'b0; fault_in = '0;
    for (int b = 0; b < 128; b++) pat[b] = '0;
    pat[5] = 8'h04;
    model(8);
    drive_run(1, 1'b0, 1'b0, lat, ns);
    n_cmp++;
    if (lat !== 10) begin n_err++; $display("FAIL midrst_rerun_lat got %0d expected 10", lat); end
    n_cmp++;
    if ({fault_map, row_fault, col_fault} !== {exp_map, exp_row, exp_col}) begin
      n_err++; $display("FAIL midrst_rerun map=%h row=%h col=%h expected %h/%h/%h", fault_map, row_fault, col_fault, exp_map, exp_row, exp_col);
    end
  endtask

  // Random runs; some start in the DONE cycle of the previous run
  task automatic test_random();
    int lat, ns, np, nb;
    bit st;
    for (int run = 0; run < 8; run++) begin
      np = $urandom_range(0, 3);
      st = 1'($urandom_range(0, 1));
      nb = ((np == 0) ? 1 : np) * DEPTH;
      for (int b = 0; b < 128; b++)
        pat[b] = ($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
      model(nb);
      drive_run(np, st, 1'b0, lat, ns);
      n_cmp++;
      if (lat !== nb + ns + 2) begin n_err++; $display("FAIL rand%0d_lat got %0d expected %0d", run, lat, nb + ns + 2); end
      n_cmp++;
      if (fault_map !== exp_map) begin n_err++; $display("FAIL rand%0d_map got %h expected %h", run, fault_map, exp_map); end
      n_cmp++;
      if ({row_fault, col_fault} !== {exp_row, exp_col}) begin
        n_err++; $display("FAIL rand%0d_rc got %h/%h expected %h/%h", run, row_fault, col_fault, exp_row, exp_col);
      end
`ifdef DIAG_FAULT_CNT_EN
      n_cmp++;
      if (fault_cnt !== 7'(exp_cnt)) begin n_err++; $display("FAIL rand%0d_cnt got %0d expected %0d", run, fault_cnt, exp_cnt); end
`endif
      if (run % 2 == 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_pe();
    test_row_fault();
    test_col_multipass();
    test_stall_busy_start();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
